// File: rtl/bus_mux_keeper.sv
// Fixed-priority bus multiplexer with a last-value keeper, optional output
// register and multi-driver conflict tracking (pulse, sticky flag, counter).
module bus_mux_keeper #(
    parameter int WIDTH     = 32,
    parameter int NSRC      = 24,
    parameter bit REG_OUT   = 1'b1,
    parameter bit HOLD_IDLE = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic                                   clock,
    input  logic                                   clear,
    input  logic [NSRC-1:0]                        src_en,
    input  logic [NSRC*WIDTH-1:0]                  src_data,
    input  logic                                   err_clr,
    output logic [WIDTH-1:0]                       bus_out,
    output logic                                   bus_valid,
    output logic [(NSRC>1 ? $clog2(NSRC) : 1)-1:0] sel_idx,
    output logic                                   conflict,
    output logic                                   conflict_err,
    output logic [CNT_W-1:0]                       conflict_cnt
);
    localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic             anyEn;
    logic             multiEn;
    logic [SEL_W-1:0] winIdx;
    logic [WIDTH-1:0] winData;
    logic [WIDTH-1:0] nextVal;
    logic [WIDTH-1:0] keeper_q, keeper_d;
    logic             conflictErr_q, conflictErr_d;
    logic [CNT_W-1:0] conflictCnt_q, conflictCnt_d;

    // Scanning from the top down lets the lowest enabled index overwrite the rest.
    always_comb begin
        winIdx  = '0;
        winData = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_en[i]) begin
                winIdx  = SEL_W'(i);
                winData = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign anyEn    = |src_en;
    assign multiEn  = |(src_en & (src_en - NSRC'(1)));
    assign nextVal  = anyEn ? winData : (HOLD_IDLE ? keeper_q : '0);
    assign keeper_d = anyEn ? winData : keeper_q;

    // A conflict in the same cycle as err_clr restarts the count at one.
    always_comb begin
        conflictErr_d = conflictErr_q;
        conflictCnt_d = conflictCnt_q;
        if (multiEn) begin
            conflictErr_d = 1'b1;
            if (err_clr) begin
                conflictCnt_d = CNT_W'(1);
            end else if (conflictCnt_q != '1) begin
                conflictCnt_d = conflictCnt_q + CNT_W'(1);
            end
        end else if (err_clr) begin
            conflictErr_d = 1'b0;
            conflictCnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            keeper_q      <= '0;
            conflictErr_q <= 1'b0;
            conflictCnt_q <= '0;
        end else begin
            keeper_q      <= keeper_d;
            conflictErr_q <= conflictErr_d;
            conflictCnt_q <= conflictCnt_d;
        end
    end

    assign conflict_err = conflictErr_q;
    assign conflict_cnt = conflictCnt_q;

    generate
        if (REG_OUT) begin : gRegOut
            logic [WIDTH-1:0] bus_q;
            logic             valid_q;
            logic [SEL_W-1:0] sel_q;
            logic             conflict_q;

            always_ff @(posedge clock or negedge clear) begin
                if (!clear) begin
                    bus_q      <= '0;
                    valid_q    <= 1'b0;
                    sel_q      <= '0;
                    conflict_q <= 1'b0;
                end else begin
                    bus_q      <= nextVal;
                    valid_q    <= anyEn;
                    sel_q      <= winIdx;
                    conflict_q <= multiEn;
                end
            end

            assign bus_out   = bus_q;
            assign bus_valid = valid_q;
            assign sel_idx   = sel_q;
            assign conflict  = conflict_q;
        end else begin : gCombOut
            // Outputs are forced to their reset values while clear is held low.
            always_comb begin
                bus_out   = '0;
                bus_valid = 1'b0;
                sel_idx   = '0;
                conflict  = 1'b0;
                if (clear) begin
                    bus_out   = nextVal;
                    bus_valid = anyEn;
                    sel_idx   = winIdx;
                    conflict  = multiEn;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_bus_mux_keeper.sv
// Randomized bench for bus_mux_keeper: three builds (registered/hold, combinational/hold,
// registered/zero-idle) share one stimulus and are compared against a behavioural model.
module tb_bus_mux_keeper;
    localparam int WIDTH = 32;
    localparam int NSRC  = 24;
    localparam int CNT_W = 8;
    localparam int SEL_W = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                  clock = 1'b0;
    logic                  clear;
    logic                  errClr;
    logic [NSRC-1:0]       srcEn;
    logic [NSRC*WIDTH-1:0] srcData;

    logic [WIDTH-1:0] aBus, bBus, cBus;
    logic             aValid, bValid, cValid;
    logic [SEL_W-1:0] aSel, bSel, cSel;
    logic             aConf, bConf, cConf;
    logic             aErr, bErr, cErr;
    logic [CNT_W-1:0] aCnt, bCnt, cCnt;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mKeeper = '0;
    logic [WIDTH-1:0] mBusHold = '0;
    logic [WIDTH-1:0] mBusZero = '0;
    logic             mValid = 1'b0;
    logic             mConf = 1'b0;
    logic             mErr = 1'b0;
    int               mSel = 0;
    int               mCnt = 0;

    always #5 clock = ~clock;

    bus_mux_keeper #(.WIDTH(WIDTH), .NSRC(NSRC), .REG_OUT(1'b1), .HOLD_IDLE(1'b1), .CNT_W(CNT_W)) dutA (
        .clock(clock), .clear(clear), .src_en(srcEn), .src_data(srcData), .err_clr(errClr),
        .bus_out(aBus), .bus_valid(aValid), .sel_idx(aSel), .conflict(aConf),
        .conflict_err(aErr), .conflict_cnt(aCnt));

    bus_mux_keeper #(.WIDTH(WIDTH), .NSRC(NSRC), .REG_OUT(1'b0), .HOLD_IDLE(1'b1), .CNT_W(CNT_W)) dutB (
        .clock(clock), .clear(clear), .src_en(srcEn), .src_data(srcData), .err_clr(errClr),
        .bus_out(bBus), .bus_valid(bValid), .sel_idx(bSel), .conflict(bConf),
        .conflict_err(bErr), .conflict_cnt(bCnt));

    bus_mux_keeper #(.WIDTH(WIDTH), .NSRC(NSRC), .REG_OUT(1'b1), .HOLD_IDLE(1'b0), .CNT_W(CNT_W)) dutC (
        .clock(clock), .clear(clear), .src_en(srcEn), .src_data(srcData), .err_clr(errClr),
        .bus_out(cBus), .bus_valid(cValid), .sel_idx(cSel), .conflict(cConf),
        .conflict_err(cErr), .conflict_cnt(cCnt));

    function automatic int firstIdx(input logic [NSRC-1:0] en);
        int idx = 0;
        bit found = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (en[i] && !found) begin
                idx = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic [WIDTH-1:0] srcWord(input int idx);
        return srcData[idx*WIDTH +: WIDTH];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what every output must hold after each edge.
    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            mKeeper = '0; mBusHold = '0; mBusZero = '0;
            mValid = 1'b0; mConf = 1'b0; mErr = 1'b0; mSel = 0; mCnt = 0;
        end else begin
            int n;
            int w;
            n = $countones(srcEn);
            w = firstIdx(srcEn);
            mBusHold = (n > 0) ? srcWord(w) : mKeeper;
            mBusZero = (n > 0) ? srcWord(w) : '0;
            mValid   = (n > 0);
            mSel     = w;
            mConf    = (n > 1);
            if (n > 1) begin
                mErr = 1'b1;
                mCnt = errClr ? 1 : ((mCnt == CNT_MAX) ? CNT_MAX : mCnt + 1);
            end else if (errClr) begin
                mErr = 1'b0;
                mCnt = 0;
            end
            if (n > 0) mKeeper = srcWord(w);
        end
    end

    always @(negedge clock) begin
        int n;
        int w;
        logic [WIDTH-1:0] combBus;
        n = $countones(srcEn);
        w = firstIdx(srcEn);
        combBus = (n > 0) ? srcWord(w) : mKeeper;
        checkOutput("A.bus", aBus, mBusHold);
        checkOutput("A.valid", 32'(aValid), 32'(mValid));
        checkOutput("A.sel", 32'(aSel), 32'(mSel));
        checkOutput("A.conflict", 32'(aConf), 32'(mConf));
        checkOutput("A.err", 32'(aErr), 32'(mErr));
        checkOutput("A.cnt", 32'(aCnt), 32'(mCnt));
        checkOutput("C.bus", cBus, mBusZero);
        checkOutput("C.valid", 32'(cValid), 32'(mValid));
        checkOutput("C.cnt", 32'(cCnt), 32'(mCnt));
        checkOutput("B.bus", bBus, clear ? combBus : '0);
        checkOutput("B.valid", 32'(bValid), clear ? 32'(n > 0) : 32'd0);
        checkOutput("B.sel", 32'(bSel), clear ? 32'(w) : 32'd0);
        checkOutput("B.conflict", 32'(bConf), clear ? 32'(n > 1) : 32'd0);
        checkOutput("B.err", 32'(bErr), 32'(mErr));
        checkOutput("B.cnt", 32'(bCnt), 32'(mCnt));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [NSRC-1:0] en, input logic clr);
        for (int i = 0; i < NSRC; i++) srcData[i*WIDTH +: WIDTH] = $urandom;
        srcEn  = en;
        errClr = clr;
    endtask

    task automatic setData(input int idx, input logic [WIDTH-1:0] val);
        srcData[idx*WIDTH +: WIDTH] = val;
    endtask

    function automatic logic [NSRC-1:0] conflictPattern();
        int a;
        int b;
        logic [NSRC-1:0] extra;
        a = $urandom_range(0, NSRC - 2);
        b = $urandom_range(a + 1, NSRC - 1);
        extra = NSRC'($urandom) & NSRC'($urandom);
        return (NSRC'(1) << a) | (NSRC'(1) << b) | extra;
    endfunction

    initial begin
        clear = 1'b0;
        applyStimulus(NSRC'(1) << 3, 1'b0);
        setData(3, 32'hDEAD_BEEF);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset.busA", aBus, 32'h0);
        checkOutput("reset.validA", 32'(aValid), 32'd0);
        checkOutput("reset.selA", 32'(aSel), 32'd0);
        checkOutput("reset.busB", bBus, 32'h0);
        checkOutput("reset.validB", 32'(bValid), 32'd0);
        checkOutput("reset.cntA", 32'(aCnt), 32'd0);
        clear = 1'b1;
        tick();
        checkOutput("release.bus", aBus, 32'hDEAD_BEEF);
        checkOutput("release.sel", 32'(aSel), 32'd3);
        checkOutput("release.valid", 32'(aValid), 32'd1);

        applyStimulus((NSRC'(1) << 2) | (NSRC'(1) << 5), 1'b0);
        setData(2, 32'h11);
        setData(5, 32'h55);
        tick();
        checkOutput("prio.bus", aBus, 32'h11);
        checkOutput("prio.sel", 32'(aSel), 32'd2);
        checkOutput("prio.conflict", 32'(aConf), 32'd1);
        checkOutput("prio.err", 32'(aErr), 32'd1);
        checkOutput("prio.cnt", 32'(aCnt), 32'd1);

        applyStimulus(NSRC'(1), 1'b0);
        setData(0, 32'hA5A5_0001);
        tick();
        checkOutput("keep.first", aBus, 32'hA5A5_0001);
        applyStimulus('0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("keep.busA", aBus, 32'hA5A5_0001);
            checkOutput("keep.validA", 32'(aValid), 32'd0);
            checkOutput("keep.busC", cBus, 32'h0);
        end

        applyStimulus(NSRC'(1) << 23, 1'b0);
        setData(23, 32'h0000_00C3);
        #1;
        checkOutput("lat.busB", bBus, 32'hC3);
        checkOutput("lat.selB", 32'(bSel), 32'd23);
        checkOutput("lat.validB", 32'(bValid), 32'd1);
        checkOutput("lat.busAold", aBus, 32'hA5A5_0001);
        tick();
        checkOutput("lat.busA", aBus, 32'hC3);
        checkOutput("lat.selA", 32'(aSel), 32'd23);

        applyStimulus('0, 1'b1);
        tick();
        checkOutput("clr.err", 32'(aErr), 32'd0);
        checkOutput("clr.cnt", 32'(aCnt), 32'd0);
        for (int k = 0; k < 300; k++) begin
            applyStimulus(conflictPattern(), 1'b0);
            tick();
        end
        checkOutput("sat.cnt", 32'(aCnt), 32'd255);
        checkOutput("sat.err", 32'(aErr), 32'd1);
        applyStimulus(conflictPattern(), 1'b1);
        tick();
        checkOutput("clrset.cnt", 32'(aCnt), 32'd1);
        checkOutput("clrset.err", 32'(aErr), 32'd1);
        applyStimulus('0, 1'b1);
        tick();
        checkOutput("clronly.cnt", 32'(aCnt), 32'd0);
        checkOutput("clronly.err", 32'(aErr), 32'd0);

        applyStimulus(NSRC'(1), 1'b0);
        setData(0, 32'h1234_5678);
        tick();
        applyStimulus('0, 1'b0);
        tick();
        checkOutput("midrst.held", aBus, 32'h1234_5678);
        #1 clear = 1'b0;
        #1;
        checkOutput("midrst.busA", aBus, 32'h0);
        checkOutput("midrst.busB", bBus, 32'h0);
        checkOutput("midrst.busC", cBus, 32'h0);
        #1 clear = 1'b1;
        tick();
        checkOutput("postrst.busA", aBus, 32'h0);
        checkOutput("postrst.validA", 32'(aValid), 32'd0);
        checkOutput("postrst.busB", bBus, 32'h0);

        for (int k = 0; k < 500; k++) begin
            logic [NSRC-1:0] en;
            case ($urandom_range(0, 3))
                0:       en = '0;
                1:       en = NSRC'(1) << $urandom_range(0, NSRC - 1);
                2:       en = NSRC'($urandom);
                default: en = conflictPattern();
            endcase
            applyStimulus(en, ($urandom_range(0, 7) == 0));
            tick();
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
